// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clock-switch control block.
// Holds the switch FSM encoding and the toggle-synchronizer depth.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    VERIFY = 2'd2,
    RESP   = 2'd3
  } switch_state_e;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/tgl_edge_detect.sv
// Brings an asynchronous toggle into clk_i and pulses edge_o for one cycle
// per transition of the synchronized value.
module tgl_edge_detect
  import clk_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic srst_i,
  input  logic tgl_i,
  output logic edge_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  hist_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], tgl_i};
      hist_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign edge_o = sync_q[SYNC_DEPTH-1] ^ hist_q;

endmodule

// File: rtl/clk_mux_switch_ctrl.sv
// Drives the clock-mux select on request, waits for the mux to settle, then
// counts output-clock edges over a fixed window and reports pass/fail.
module clk_mux_switch_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 256,
  parameter int CNT_W         = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             req_valid_i,
  input  logic             req_sel_i,
  output logic             req_ready_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_ok_o,
  output logic [CNT_W-1:0] rsp_count_o,
  input  logic [CNT_W-1:0] exp_min0_i,
  input  logic [CNT_W-1:0] exp_max0_i,
  input  logic [CNT_W-1:0] exp_min1_i,
  input  logic [CNT_W-1:0] exp_max1_i,
  input  logic             mon_tgl_i,
  output logic             sel_o,
  output logic             busy_o,
  output switch_state_e    state_o
);

  // Handshakes: a transfer happens on a clk_i edge where valid and ready are
  // both high; a response, once valid, holds its payload until rsp_ready_i.

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  switch_state_e    state, state_nxt;
  logic             sel_q;
  logic [CNT_W-1:0] min_q, max_q;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_sum;
  logic [CNT_W-1:0] rsp_count_q;
  logic             rsp_ok_q;
  logic             edge_det;

  tgl_edge_detect u_edge (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .tgl_i  (mon_tgl_i),
    .edge_o (edge_det)
  );

  // Count including the current cycle's edge, saturating at all-ones.
  assign edge_sum = (edge_det && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;

  always_ff @(posedge clk_i) begin
    if (srst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i)               state_nxt = SWITCH;
      SWITCH:  if (settle_cnt == SETTLE_LAST) state_nxt = VERIFY;
      VERIFY:  if (win_cnt == WIN_LAST)       state_nxt = RESP;
      RESP:    if (rsp_ready_i)               state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sel_q       <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      settle_cnt  <= '0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
      rsp_count_q <= '0;
      rsp_ok_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            sel_q      <= req_sel_i;
            min_q      <= req_sel_i ? exp_min1_i : exp_min0_i;
            max_q      <= req_sel_i ? exp_max1_i : exp_max0_i;
            settle_cnt <= '0;
          end
        end
        SWITCH: begin
          // Edges during settling are discarded; counters start clean.
          settle_cnt <= settle_cnt + 1'b1;
          win_cnt    <= '0;
          edge_cnt   <= '0;
        end
        VERIFY: begin
          win_cnt  <= win_cnt + 1'b1;
          edge_cnt <= edge_sum;
          if (win_cnt == WIN_LAST) begin
            rsp_count_q <= edge_sum;
            rsp_ok_q    <= (min_q <= edge_sum) && (edge_sum <= max_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign sel_o       = sel_q;
  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_ok_o    = rsp_ok_q;
  assign rsp_count_o = rsp_count_q;
  assign state_o     = state;

endmodule

// File: tb/tb_clk_mux_switch_ctrl.sv
// Directed bench for clk_mux_switch_ctrl: default-sized instance for switch,
// stopped-clock, backpressure and reset cases; small-window instance for the rest.
module tb_clk_mux_switch_ctrl;
  import clk_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       srst, mon_tgl;
  int         tgl_period;
  // default instance: SETTLE=16, WINDOW=256, CNT_W=9
  logic       req_valid, req_sel, req_ready, rsp_valid, rsp_ready, rsp_ok, sel, busy;
  logic [8:0] rsp_count, min0, max0, min1, max1;
  switch_state_e state;
  // small instance: SETTLE=2, WINDOW=8, CNT_W=4
  logic       s_req_valid, s_req_sel, s_req_ready, s_rsp_valid, s_rsp_ready, s_rsp_ok, s_sel, s_busy;
  logic [3:0] s_rsp_count, s_min0, s_max0, s_min1, s_max1;
  switch_state_e s_state;

  clk_mux_switch_ctrl dut (
    .clk_i(clk), .srst_i(srst), .req_valid_i(req_valid), .req_sel_i(req_sel),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_ok_o(rsp_ok), .rsp_count_o(rsp_count),
    .exp_min0_i(min0), .exp_max0_i(max0), .exp_min1_i(min1), .exp_max1_i(max1),
    .mon_tgl_i(mon_tgl), .sel_o(sel), .busy_o(busy), .state_o(state)
  );

  clk_mux_switch_ctrl #(.SETTLE_CYCLES(2), .WINDOW_CYCLES(8)) dut_s (
    .clk_i(clk), .srst_i(srst), .req_valid_i(s_req_valid), .req_sel_i(s_req_sel),
    .req_ready_o(s_req_ready), .rsp_valid_o(s_rsp_valid), .rsp_ready_i(s_rsp_ready),
    .rsp_ok_o(s_rsp_ok), .rsp_count_o(s_rsp_count),
    .exp_min0_i(s_min0), .exp_max0_i(s_max0), .exp_min1_i(s_min1), .exp_max1_i(s_max1),
    .mon_tgl_i(mon_tgl), .sel_o(s_sel), .busy_o(s_busy), .state_o(s_state)
  );

  // Output-clock stand-in: flips every tgl_period ref cycles, 0 = stopped.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (tgl_period != 0) begin
        ph++;
        if (ph >= tgl_period) begin
          ph = 0;
          mon_tgl = ~mon_tgl;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [8:0] hold_count;
    logic       hold_ok;

    srst = 1'b1; mon_tgl = 1'b0; tgl_period = 0;
    req_valid = 0; req_sel = 0; rsp_ready = 0;
    min0 = 9'd0; max0 = 9'd5; min1 = 9'd60; max1 = 9'd68;
    s_req_valid = 0; s_req_sel = 0; s_rsp_ready = 1;
    s_min0 = 4'd0; s_max0 = 4'd0; s_min1 = 4'd2; s_max1 = 4'd4;

    // Reset
    repeat (3) tick();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_ok", 32'(rsp_ok), 0);
    chk("rst_rsp_count", 32'(rsp_count), 0);
    chk("rst_state", 32'(state), 32'(IDLE));
    srst = 1'b0;

    // Switch to clk1, output toggling every 4 ref cycles -> 64 edges/256
    tgl_period = 4;
    repeat (5) tick();
    req_valid = 1; req_sel = 1;
    tick();                                   // cycle 1
    req_valid = 0;
    chk("sw_sel_c1", 32'(sel), 1);
    chk("sw_busy_c1", 32'(busy), 1);
    chk("sw_req_ready_c1", 32'(req_ready), 0);
    chk("sw_state_c1", 32'(state), 32'(SWITCH));
    repeat (15) tick();                       // cycle 16
    chk("sw_state_c16", 32'(state), 32'(SWITCH));
    tick();                                   // cycle 17
    chk("sw_state_c17", 32'(state), 32'(VERIFY));
    repeat (255) tick();                      // cycle 272
    chk("sw_rsp_valid_c272", 32'(rsp_valid), 0);
    tick();                                   // cycle 273
    chk("sw_rsp_valid_c273", 32'(rsp_valid), 1);
    chk("sw_rsp_count", 32'(rsp_count), 64);
    chk("sw_rsp_ok", 32'(rsp_ok), 1);

    // Backpressure: hold for 10 cycles, response must stay put
    hold_count = rsp_count; hold_ok = rsp_ok;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_count", 32'(rsp_count), 32'(hold_count));
      chk("bp_rsp_ok", 32'(rsp_ok), 32'(hold_ok));
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    // Handshake with a new request (stopped clock, sel=0) already waiting
    tgl_period = 0;
    min0 = 9'd60; max0 = 9'd68;
    rsp_ready = 1; req_valid = 1; req_sel = 0;
    chk("hs_req_ready_busy", 32'(req_ready), 0);
    tick();
    chk("hs_rsp_valid_drop", 32'(rsp_valid), 0);
    chk("hs_req_ready_idle", 32'(req_ready), 1);
    chk("hs_busy_idle", 32'(busy), 0);
    tick();                                   // cycle 1 of second request
    req_valid = 0;
    chk("stop_busy_c1", 32'(busy), 1);
    chk("stop_sel_c1", 32'(sel), 0);
    n = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
    end
    chk("stop_latency", 32'(n), 272);
    chk("stop_rsp_count", 32'(rsp_count), 0);
    chk("stop_rsp_ok", 32'(rsp_ok), 0);
    tick();
    chk("stop_one_cycle_rsp", 32'(rsp_valid), 0);
    chk("stop_busy_end", 32'(busy), 0);

    // Reset in the middle of VERIFY
    tgl_period = 4;
    req_valid = 1; req_sel = 1;
    tick();                                   // cycle 1
    req_valid = 0;
    repeat (99) tick();                       // cycle 100
    chk("mid_state_c100", 32'(state), 32'(VERIFY));
    srst = 1;
    tick();
    srst = 0;
    chk("mid_sel", 32'(sel), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_state", 32'(state), 32'(IDLE));
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rsp_valid) seen = 1;
    end
    chk("mid_no_rsp", 32'(seen), 0);

    // Small window: ~3 edges at f/3, bounds changed during VERIFY
    tgl_period = 3;
    repeat (4) tick();
    s_req_valid = 1; s_req_sel = 1;
    tick();                                   // cycle 1
    s_req_valid = 0;
    chk("s_sel_c1", 32'(s_sel), 1);
    repeat (2) tick();                        // cycle 3
    chk("s_state_c3", 32'(s_state), 32'(VERIFY));
    s_min1 = 4'd10; s_max1 = 4'd15;
    n = 0;
    while (!s_rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("s_latency", 32'(n), 8);
    chk("s_count_in_2_3", 32'((s_rsp_count >= 4'd2) && (s_rsp_count <= 4'd3)), 1);
    chk("s_rsp_ok", 32'(s_rsp_ok), 1);
    tick();
    chk("s_rsp_done", 32'(s_rsp_valid), 0);

    // min > max always fails
    s_min0 = 4'd3; s_max0 = 4'd2;
    s_req_valid = 1; s_req_sel = 0;
    tick();
    s_req_valid = 0;
    n = 0;
    while (!s_rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("s_inv_latency", 32'(n), 10);
    chk("s_inv_sel", 32'(s_sel), 0);
    chk("s_inv_ok", 32'(s_rsp_ok), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
